lsu_bus: RTL and testbench

- Load/store unit directly downstream of the core's ALU.
- Takes the effective address, store data and access type produced by the execute datapath.
- Drives a word-wide, handshaked data bus in place of the zero-latency data memory.
- Returns aligned, sign/zero-extended load data to the write-back mux, and tells the core when to stall.

---
 rtl/lsu_bus_if.sv | 22 ++
 rtl/lsu_bus.sv | 178 +++++++++++++++++
 tb/tb_lsu_bus.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_bus_if.sv
// Word-wide handshaked data bus between the load/store unit (master) and
// the data-side slave: request/grant for address phase, rvalid for response.
interface lsu_bus_if;
  logic        req;
  logic        gnt;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req, we, be, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/lsu_bus.sv
// Load/store unit between the execute stage and a handshaked data bus:
// lane steering, load extension, alignment checks and response timeout.
module lsu_bus #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        core_valid_i,
  output logic        core_ready_o,
  input  logic        core_we_i,
  input  logic [2:0]  core_funct3_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wdata_i,
  output logic        core_done_o,
  output logic        core_err_o,
  output logic [31:0] core_rdata_o,
  lsu_bus_if.master   bus
);

  localparam logic [15:0] TimeoutCnt = 16'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [3:0]  be_q, be_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;
  logic [15:0] cnt_q, cnt_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        legal;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;
  logic [31:0] shifted;
  logic [31:0] load_data;

  always_comb begin
    legal     = 1'b0;
    be_new    = 4'b1111;
    wdata_new = core_wdata_i;
    case (core_funct3_i)
      3'b000:         legal = 1'b1;
      3'b001:         legal = ~core_addr_i[0];
      3'b010:         legal = (core_addr_i[1:0] == 2'b00);
      3'b100:         legal = ~core_we_i;
      3'b101:         legal = ~core_we_i & ~core_addr_i[0];
      default:        legal = 1'b0;
    endcase
    case (core_funct3_i[1:0])
      2'b00: begin
        be_new    = 4'b0001 << core_addr_i[1:0];
        wdata_new = {4{core_wdata_i[7:0]}};
      end
      2'b01: begin
        be_new    = 4'b0011 << core_addr_i[1:0];
        wdata_new = {2{core_wdata_i[15:0]}};
      end
      default: begin
        be_new    = 4'b1111;
        wdata_new = core_wdata_i;
      end
    endcase
  end

  // Move the addressed byte/halfword down to bit 0, then extend it.
  always_comb begin
    shifted   = bus.rdata >> {off_q, 3'b000};
    load_data = shifted;
    case (funct3_q)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_data = {24'd0, shifted[7:0]};
      3'b101:  load_data = {16'd0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    be_d     = be_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    off_d    = off_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (core_valid_i) begin
          addr_d   = {core_addr_i[31:2], 2'b00};
          wdata_d  = wdata_new;
          be_d     = be_new;
          we_d     = core_we_i;
          funct3_d = core_funct3_i;
          off_d    = core_addr_i[1:0];
          if (legal) begin
            state_d = REQ;
          end else begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end
        end
      end
      REQ: begin
        if (bus.gnt) begin
          state_d = RESP;
          cnt_d   = 16'd0;
        end
      end
      RESP: begin
        // A response in the last allowed cycle still wins over the timeout.
        if (bus.rvalid) begin
          state_d = IDLE;
          done_d  = 1'b1;
          if (!we_q) begin
            rdata_d = load_data;
          end
        end else if (cnt_q == TimeoutCnt) begin
          state_d = IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      be_q     <= '0;
      we_q     <= 1'b0;
      funct3_q <= '0;
      off_q    <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      be_q     <= be_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      off_q    <= off_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign core_ready_o = (state_q == IDLE);
  assign core_done_o  = done_q;
  assign core_err_o   = err_q;
  assign core_rdata_o = rdata_q;

  // bus_req is decoded from state so an async reset removes it at once.
  assign bus.req   = (state_q == REQ);
  assign bus.we    = we_q;
  assign bus.be    = be_q;
  assign bus.addr  = addr_q;
  assign bus.wdata = wdata_q;

endmodule

// File: tb/tb_lsu_bus.sv
// Directed bench for lsu_bus: a transaction-timeline model sets the expected
// outputs cycle by cycle and one negedge process compares the DUT against it.
module tb_lsu_bus;
  localparam int Timeout = 4;

  logic        clk = 1'b0;
  logic        rstN;
  logic        coreValid, coreReady, coreWe;
  logic [2:0]  coreF3;
  logic [31:0] coreAddr, coreWdata;
  logic        coreDone, coreErr;
  logic [31:0] coreRdata;

  lsu_bus_if busIf ();

  lsu_bus #(.TIMEOUT(Timeout)) dut (
    .clk_i        (clk),
    .rst_ni       (rstN),
    .core_valid_i (coreValid),
    .core_ready_o (coreReady),
    .core_we_i    (coreWe),
    .core_funct3_i(coreF3),
    .core_addr_i  (coreAddr),
    .core_wdata_i (coreWdata),
    .core_done_o  (coreDone),
    .core_err_o   (coreErr),
    .core_rdata_o (coreRdata),
    .bus          (busIf)
  );

  always #5 clk = ~clk;

  int          assertCount = 0;
  int          failCount   = 0;
  int          cycleNo     = 0;
  int          acceptCycle = 0;
  int          doneCycle   = -1;
  int          doneCount   = 0;

  logic        expReady, expReq, expDone, expErr, expWe;
  logic [31:0] expRdata, expAddr, expWdata;
  logic [3:0]  expBe;
  logic        pendDone, pendErr, pendLoad;
  logic [31:0] pendRdata;
  logic        lateRv;

  logic [31:0] lastAddr, lastWdata, lastAcceptRdata;
  logic [3:0]  lastBe;
  logic        lastWe;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    assertCount++;
    if (got !== want) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, got, want);
    end
  endtask

  // Reference model: access width, legality, lanes and load extension.
  function automatic int accBytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit modelLegal(input logic we, input logic [2:0] f3, input logic [31:0] a);
    if (f3[1:0] == 2'b11) return 1'b0;
    if (f3[2] && (we || f3[1:0] == 2'b10)) return 1'b0;
    return (int'(a[1:0]) % accBytes(f3)) == 0;
  endfunction

  function automatic logic [3:0] modelBe(input logic [2:0] f3, input logic [31:0] a);
    int m;
    m = (1 << accBytes(f3)) - 1;
    return 4'(m << int'(a[1:0]));
  endfunction

  function automatic logic [31:0] modelWdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] r;
    int n;
    n = accBytes(f3);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    longint v;
    int bits;
    bits = 8 * accBytes(f3);
    v = longint'(rd >> (8 * int'(a[1:0])));
    if (bits < 32) begin
      v = v & ((longint'(1) << bits) - 1);
      if (!f3[2] && v[bits-1]) v = v - (longint'(1) << bits);
    end
    return v[31:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cycleNo++;
    expDone = pendDone;
    expErr  = pendErr;
    if (pendDone && pendLoad) expRdata = pendRdata;
    pendDone = 1'b0;
    pendErr  = 1'b0;
    pendLoad = 1'b0;
  endtask

  task automatic idleCycle();
    step();
    coreValid    = 1'b0;
    busIf.gnt    = 1'b0;
    busIf.rvalid = lateRv;
    expReady     = 1'b1;
    expReq       = 1'b0;
  endtask

  // rvWait < 0 means the slave never responds.
  task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] wd, input int gntWait, input int rvWait,
                               input logic [31:0] rd);
    step();
    lastAcceptRdata = coreRdata;
    coreValid    = 1'b1;
    coreWe       = we;
    coreF3       = f3;
    coreAddr     = a;
    coreWdata    = wd;
    busIf.gnt    = 1'b0;
    busIf.rvalid = 1'b0;
    expReady     = 1'b1;
    expReq       = 1'b0;
    acceptCycle  = cycleNo;
    if (!modelLegal(we, f3, a)) begin
      pendDone = 1'b1;
      pendErr  = 1'b1;
      return;
    end
    expAddr  = {a[31:2], 2'b00};
    expBe    = modelBe(f3, a);
    expWdata = modelWdata(f3, wd);
    expWe    = we;
    for (int k = 0; k <= gntWait; k++) begin
      step();
      expReady     = 1'b0;
      expReq       = 1'b1;
      busIf.gnt    = (k == gntWait);
      busIf.rvalid = lateRv;
      if (k == 0) begin
        lastAddr  = busIf.addr;
        lastBe    = busIf.be;
        lastWdata = busIf.wdata;
        lastWe    = busIf.we;
      end
    end
    if (rvWait < 0) begin
      for (int k = 0; k <= Timeout; k++) begin
        step();
        expReady     = 1'b0;
        expReq       = 1'b0;
        busIf.gnt    = 1'b0;
        busIf.rvalid = 1'b0;
      end
      pendDone = 1'b1;
      pendErr  = 1'b1;
    end else begin
      for (int k = 0; k <= rvWait; k++) begin
        step();
        expReady     = 1'b0;
        expReq       = 1'b0;
        busIf.gnt    = 1'b0;
        busIf.rvalid = (k == rvWait);
        busIf.rdata  = (k == rvWait) ? rd : 32'h5A5A_5A5A;
      end
      pendDone  = 1'b1;
      pendErr   = 1'b0;
      pendLoad  = !we;
      pendRdata = modelLoad(f3, a, rd);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      checkOutput("core_ready", 32'(coreReady), 32'(expReady));
      checkOutput("bus_req", 32'(busIf.req), 32'(expReq));
      checkOutput("core_done", 32'(coreDone), 32'(expDone));
      checkOutput("core_err", 32'(coreErr), 32'(expErr));
      checkOutput("core_rdata", coreRdata, expRdata);
      if (expReq) begin
        checkOutput("bus_addr", busIf.addr, expAddr);
        checkOutput("bus_be", 32'(busIf.be), 32'(expBe));
        checkOutput("bus_we", 32'(busIf.we), 32'(expWe));
        if (expWe) checkOutput("bus_wdata", busIf.wdata, expWdata);
      end
      if (coreDone) begin
        doneCycle = cycleNo;
        doneCount++;
      end
    end
  end

  initial begin
    int doneBase;
    rstN = 1'b0;
    coreValid = 1'b0; coreWe = 1'b0; coreF3 = 3'b000; coreAddr = '0; coreWdata = '0;
    busIf.gnt = 1'b0; busIf.rvalid = 1'b0; busIf.rdata = '0;
    expReady = 1'b1; expReq = 1'b0; expDone = 1'b0; expErr = 1'b0; expWe = 1'b0;
    expRdata = '0; expAddr = '0; expWdata = '0; expBe = '0;
    pendDone = 1'b0; pendErr = 1'b0; pendLoad = 1'b0; pendRdata = '0; lateRv = 1'b0;

    step();
    step();
    checkOutput("reset_bus_addr", busIf.addr, 32'h0);
    checkOutput("reset_bus_be", 32'(busIf.be), 32'h0);
    checkOutput("reset_bus_wdata", busIf.wdata, 32'h0);
    checkOutput("reset_bus_we", 32'(busIf.we), 32'h0);
    rstN = 1'b1;
    idleCycle();

    // Zero-wait LW
    applyStimulus(1'b0, 3'b010, 32'h100, 32'h0, 0, 0, 32'hDEAD_BEEF);
    checkOutput("lw_bus_addr", lastAddr, 32'h100);
    checkOutput("lw_bus_be", 32'(lastBe), 32'hF);
    idleCycle();
    checkOutput("lw_rdata", coreRdata, 32'hDEAD_BEEF);
    idleCycle();
    checkOutput("lw_latency", 32'(doneCycle - acceptCycle), 32'd3);

    // Back-to-back sign/zero-extended loads
    applyStimulus(1'b0, 3'b000, 32'h103, 32'h0, 0, 0, 32'h8011_2233);
    applyStimulus(1'b0, 3'b100, 32'h103, 32'h0, 0, 0, 32'h8011_2233);
    checkOutput("lb_rdata", lastAcceptRdata, 32'hFFFF_FF80);
    idleCycle();
    checkOutput("lbu_rdata", coreRdata, 32'h0000_0080);
    applyStimulus(1'b0, 3'b101, 32'h102, 32'h0, 0, 0, 32'h8011_2233);
    idleCycle();
    checkOutput("lhu_rdata", coreRdata, 32'h0000_8011);

    // Stores
    applyStimulus(1'b1, 3'b000, 32'h201, 32'h0000_00A5, 0, 0, 32'h0);
    checkOutput("sb_bus_we", 32'(lastWe), 32'h1);
    checkOutput("sb_bus_be", 32'(lastBe), 32'b0010);
    checkOutput("sb_bus_wdata", lastWdata, 32'hA5A5_A5A5);
    checkOutput("sb_bus_addr", lastAddr, 32'h200);
    idleCycle();
    checkOutput("sb_rdata_kept", coreRdata, 32'h0000_8011);
    applyStimulus(1'b1, 3'b001, 32'h202, 32'h0000_1234, 0, 0, 32'h0);
    checkOutput("sh_bus_be", 32'(lastBe), 32'b1100);
    checkOutput("sh_bus_wdata", lastWdata, 32'h1234_1234);
    idleCycle();

    // Illegal accesses: no bus cycle, error pulse one cycle after accept
    applyStimulus(1'b0, 3'b010, 32'h102, 32'h0, 0, 0, 32'h0);
    applyStimulus(1'b1, 3'b001, 32'h103, 32'h0, 0, 0, 32'h0);
    applyStimulus(1'b0, 3'b011, 32'h100, 32'h0, 0, 0, 32'h0);
    idleCycle();
    checkOutput("illegal_err", 32'(coreErr), 32'h1);
    idleCycle();
    checkOutput("illegal_rdata_kept", coreRdata, 32'h0000_8011);

    // Wait states with a stray rvalid during the grant wait
    doneBase = doneCount;
    lateRv = 1'b1;
    applyStimulus(1'b0, 3'b010, 32'h300, 32'h0, 3, 4, 32'hCAFE_F00D);
    lateRv = 1'b0;
    idleCycle();
    idleCycle();
    idleCycle();
    checkOutput("wait_rdata", coreRdata, 32'hCAFE_F00D);
    checkOutput("wait_done_pulses", 32'(doneCount - doneBase), 32'd1);

    // Timeout, then a late rvalid in IDLE
    applyStimulus(1'b0, 3'b010, 32'h400, 32'h0, 0, -1, 32'h0);
    lateRv = 1'b1;
    idleCycle();
    checkOutput("timeout_err", 32'(coreErr), 32'h1);
    idleCycle();
    idleCycle();
    lateRv = 1'b0;
    idleCycle();
    checkOutput("timeout_rdata_kept", coreRdata, 32'hCAFE_F00D);

    // Reset while in REQ
    step();
    coreValid = 1'b1; coreWe = 1'b0; coreF3 = 3'b010; coreAddr = 32'h500;
    expReady = 1'b1; expReq = 1'b0;
    step();
    expReady = 1'b0; expReq = 1'b1;
    expAddr = 32'h500; expBe = 4'hF; expWe = 1'b0;
    #2;
    rstN = 1'b0;
    expReq = 1'b0; expReady = 1'b1; expRdata = '0;
    #1;
    checkOutput("rst_bus_req", 32'(busIf.req), 32'h0);
    checkOutput("rst_core_ready", 32'(coreReady), 32'h1);
    coreValid = 1'b0;
    step();
    step();
    rstN = 1'b1;
    idleCycle();
    idleCycle();

    // Recovery after reset
    applyStimulus(1'b0, 3'b001, 32'h602, 32'h0, 1, 1, 32'h8765_4321);
    idleCycle();
    checkOutput("lh_rdata", coreRdata, 32'hFFFF_8765);
    idleCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
